// File: rtl/cook_sequencer.sv
// ---------------------------------------------------------------------------
// cook_sequencer
//   Microwave cook-cycle controller. Captures the cook time from keypad
//   digits, runs the IDLE/COOKING/PAUSED/DONE state machine, counts the time
//   down once per second while cooking, and duty-cycles the magnetron by
//   power level.
//
// Ports
//   i_clk            system clock, all state on rising edge
//   i_rst            synchronous active-high reset
//   i_startn         start button, active low, level-sampled
//   i_stopn          stop/pause button, active low
//   i_clearn         clear button, active low
//   i_door_closed    1 = door closed
//   i_key_valid      one-cycle strobe qualifying i_key_digit
//   i_key_digit      BCD digit 0..9 (values >9 ignored)
//   i_power_level    0..3, sampled at cook start and each second boundary
//   o_time_bcd       {min_tens, min_ones, sec_tens, sec_ones}
//   o_state          0 IDLE, 1 COOKING, 2 PAUSED, 3 DONE
//   o_mag_on         magnetron enable (combinational on i_door_closed)
//   o_timer_done     high while in DONE
//   o_beep           audible alert, high while in DONE
// ---------------------------------------------------------------------------
module cook_sequencer #(
    parameter int unsigned TICKS_PER_SEC = 50_000_000,
    parameter int unsigned BEEP_SECS     = 3
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_startn,
    input  logic        i_stopn,
    input  logic        i_clearn,
    input  logic        i_door_closed,
    input  logic        i_key_valid,
    input  logic [3:0]  i_key_digit,
    input  logic [1:0]  i_power_level,
    output logic [15:0] o_time_bcd,
    output logic [1:0]  o_state,
    output logic        o_mag_on,
    output logic        o_timer_done,
    output logic        o_beep
);

    localparam int unsigned TICK_W = $clog2(TICKS_PER_SEC);
    localparam int unsigned BEEP_W = $clog2(BEEP_SECS + 1);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_SEC - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SECS - 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COOKING = 2'd1;
    localparam logic [1:0] S_PAUSED  = 2'd2;
    localparam logic [1:0] S_DONE    = 2'd3;

    logic [1:0]        r_state;
    logic [15:0]       r_time;
    logic [TICK_W-1:0] r_tick;
    logic [1:0]        r_phase;
    logic [BEEP_W-1:0] r_beep_cnt;
    logic [1:0]        r_power;

    logic [1:0]        w_state_nxt;
    logic [15:0]       w_time_nxt;
    logic [TICK_W-1:0] w_tick_nxt;
    logic [1:0]        w_phase_nxt;
    logic [BEEP_W-1:0] w_beep_nxt;
    logic [1:0]        w_power_nxt;
    logic              w_sec_tick;
    logic              w_time_zero;
    logic [15:0]       w_time_dec;

    // Mixed-radix countdown: seconds ones/tens wrap 0->9/0->5, minutes are decimal.
    // Seconds fields 60..99 simply count down as entered.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else begin
            so = 4'd9;
            if (st != 4'd0) begin
                st = st - 4'd1;
            end else begin
                st = 4'd5;
                if (mo != 4'd0) begin
                    mo = mo - 4'd1;
                end else begin
                    mo = 4'd9;
                    mt = mt - 4'd1;
                end
            end
        end
        return {mt, mo, st, so};
    endfunction

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_time     <= '0;
            r_tick     <= '0;
            r_phase    <= '0;
            r_beep_cnt <= '0;
            r_power    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_time     <= w_time_nxt;
            r_tick     <= w_tick_nxt;
            r_phase    <= w_phase_nxt;
            r_beep_cnt <= w_beep_nxt;
            r_power    <= w_power_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_tick_nxt  = r_tick;
        w_phase_nxt = r_phase;
        w_beep_nxt  = r_beep_cnt;
        w_power_nxt = r_power;
        w_sec_tick  = (r_tick == TICK_LAST);
        w_time_zero = (r_time == 16'h0000);
        w_time_dec  = bcd_dec(r_time);

        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                w_beep_nxt = '0;
                if (!i_clearn) begin
                    w_time_nxt = '0;
                end else begin
                    if (i_key_valid && (i_key_digit <= 4'd9)) begin
                        w_time_nxt = {r_time[11:0], i_key_digit};
                    end
                    // Start qualifies on the registered time, so a digit typed
                    // while start is held begins cooking one cycle later.
                    if (!i_startn && i_door_closed && !w_time_zero) begin
                        w_state_nxt = S_COOKING;
                        w_phase_nxt = '0;
                        w_power_nxt = i_power_level;
                    end
                end
            end

            S_COOKING: begin
                if (!i_clearn) begin
                    w_state_nxt = S_IDLE;
                    w_time_nxt  = '0;
                    w_tick_nxt  = '0;
                end else if (!i_door_closed || !i_stopn) begin
                    // A coincident second tick is dropped: no decrement, no phase step.
                    w_state_nxt = S_PAUSED;
                    w_tick_nxt  = '0;
                end else if (w_sec_tick) begin
                    w_tick_nxt  = '0;
                    w_time_nxt  = w_time_dec;
                    w_phase_nxt = r_phase + 2'd1;
                    w_power_nxt = i_power_level;
                    if (w_time_dec == 16'h0000) begin
                        w_state_nxt = S_DONE;
                        w_beep_nxt  = '0;
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end

            S_PAUSED: begin
                w_tick_nxt = '0;
                if (!i_clearn) begin
                    w_state_nxt = S_IDLE;
                    w_time_nxt  = '0;
                end else if (!i_startn && i_door_closed && i_stopn) begin
                    w_state_nxt = S_COOKING;
                    w_power_nxt = i_power_level;
                end
            end

            S_DONE: begin
                if (!i_clearn || !i_stopn || !i_door_closed) begin
                    w_state_nxt = S_IDLE;
                    w_time_nxt  = '0;
                    w_tick_nxt  = '0;
                    w_beep_nxt  = '0;
                end else if (w_sec_tick) begin
                    w_tick_nxt = '0;
                    if (r_beep_cnt == BEEP_LAST) begin
                        w_state_nxt = S_IDLE;
                        w_time_nxt  = '0;
                        w_beep_nxt  = '0;
                    end else begin
                        w_beep_nxt = r_beep_cnt + BEEP_W'(1);
                    end
                end else begin
                    w_tick_nxt = r_tick + TICK_W'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_time_bcd   = r_time;
    assign o_state      = r_state;
    assign o_timer_done = (r_state == S_DONE);
    assign o_beep       = (r_state == S_DONE);

    // Door interlock acts directly on the enable, ahead of the state register.
    assign o_mag_on = (r_state == S_COOKING) && i_door_closed && (r_phase <= r_power);

endmodule

// File: doc/cook_sequencer.md
# cook_sequencer

Cook-cycle controller for the microwave. It captures the cook time from keypad digits and runs the start/stop/clear/door state machine. While cooking it counts the time down once per second and gates the magnetron on and off according to the selected power level. It sits between the keypad/button front end and the magnetron drive, and supplies the BCD time to the display and the end-of-cycle `timer_done`/`beep` indications.

## Interface
- `TICKS_PER_SEC`, 50_000_000: clk cycles per cook second (≥2).
- `BEEP_SECS`, 3: seconds `beep` stays high in DONE (≥1).

- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `startn`  in  1  start button, active low, level-sampled
- `stopn`  in  1  stop/pause button, active low
- `clearn`  in  1  clear button, active low
- `door_closed`  in  1  1 = door closed
- `key_valid`  in  1  one-cycle strobe, `key_digit` valid
- `key_digit`  in  4  BCD digit 0–9; values >9 ignored
- `power_level`  in  2  0..3, sampled each second boundary
- `time_bcd`  out  16  {min_tens, min_ones, sec_tens, sec_ones}, BCD
- `state`  out  2  0 IDLE, 1 COOKING, 2 PAUSED, 3 DONE
- `mag_on`  out  1  magnetron enable
- `timer_done`  out  1  high while in DONE
- `beep`  out  1  audible alert

## Operation
- Reset values: state IDLE, `time_bcd` = 0, tick counter = 0, duty phase = 0, beep-second count = 0. All outputs are 0.
- IDLE:
  - `key_valid` with a digit ≤9 shifts left: time ← {time[11:0], digit}. The oldest digit drops.
  - `clearn`=0 → time ← 0.
  - `startn`=0 && `door_closed` && time≠0 → COOKING, with tick counter and duty phase set to 0.
  - Start with time = 0 is ignored.
- COOKING, priority high→low:
  1. `clearn`=0 → IDLE, time ← 0.
  2. `door_closed`=0 or `stopn`=0 → PAUSED. Time is held and the tick counter is set to 0.
  3. Second tick → decrement time.
- Keys are ignored outside IDLE.
- Decrement rule:
  - sec_ones>0 → sec_ones−1.
  - Otherwise sec_ones←9, then:
    - sec_tens>0 → sec_tens−1.
    - Otherwise sec_tens←5, then:
      - min_ones>0 → min_ones−1.
      - Otherwise min_ones←9 and min_tens−1.
  - Seconds fields 60–99 as entered count down unchanged (e.g. 0090 → 0089).
- The decrement that produces 0000 moves to DONE on the same edge.
- PAUSED:
  - `clearn`=0 → IDLE, time ← 0.
  - `startn`=0 && `door_closed` && `stopn`=1 → COOKING. Duty phase is retained.
- DONE:
  - `timer_done`=1 and `beep`=1.
  - Counts BEEP_SECS second ticks, then → IDLE with time = 0.
  - `clearn`=0, `stopn`=0 or door open → IDLE immediately.
- Duty:
  - Phase counter 0..3 increments on each COOKING second tick and wraps 3→0.
  - `mag_on` = (state==COOKING) && `door_closed` && (phase ≤ `power_level`).
  - power 3 = 100%; power 0 = 1 s on / 3 s off.
- Safety: `mag_on` is combinational on `door_closed`. An open door drops `mag_on` in the same cycle, before the state register changes.

## Timing
- Tick counter runs only in COOKING and DONE. It counts 0..TICKS_PER_SEC−1; a second tick occurs when count = TICKS_PER_SEC−1, and the counter then wraps to 0.
- First decrement occurs TICKS_PER_SEC cycles after the edge that enters COOKING.
- Button-to-state latency is 1 cycle. `time_bcd`, `state`, `timer_done` and `beep` are registered or decoded directly from registered state.
- Simultaneous events:
  - clear + door open in COOKING → IDLE.
  - stop + start in PAUSED → stays PAUSED.
  - Second tick coinciding with door open → PAUSED, no decrement.
- `rst` mid-cook → next cycle IDLE, time 0, `mag_on` 0.
- A held `startn` in IDLE with time 0 never starts a cycle. Entering digits while `startn` is held low starts the cycle on the first cycle in which time≠0.

## Test plan
Parameter overrides for the bench: TICKS_PER_SEC=4, BEEP_SECS=2.
- Keys 1,2,3,4,5 → `time_bcd`=0x2345. Then `key_digit`=0xA → unchanged. Then `clearn` low → 0x0000.
- Enter 0003, power 3, door closed, start:
  - `mag_on`=1 for 12 cycles; time steps 3,2,1,0 at 4-cycle intervals.
  - At 0000 → DONE; `beep`=1 for 8 cycles → IDLE.
- Enter 0100, start, run 1 s → 0059. Enter 0090 → after 1 s, 0089.
- Power 0, time 0008, door closed:
  - `mag_on` pattern per second is 1,0,0,0,1,0,0,0.
  - Open the door mid-second → `mag_on` 0 in the same cycle; state PAUSED next cycle; time held.
  - Close the door and press start → COOKING resumes from the held time.
- Corner cases:
  - Start with time 0 → stays IDLE.
  - Clear + door open during COOKING → IDLE with time 0.
  - `rst` during DONE → all outputs 0 next cycle.
